// File: rtl/alarm_pkg.sv
// alarm_pkg: shared time constants, invalid-time markers and scheduler state encoding
package alarm_pkg;
    localparam int MIN_PER_HOUR = 60;
    localparam int HOURS_PER_DAY = 24;
    localparam logic [5:0] INVALID_MIN = 6'h3F;
    localparam logic [4:0] INVALID_HOUR = 5'h1F;
    typedef enum logic [1:0] {SCAN, RING, SNZ} state_t;
endpackage

// File: rtl/alarm_time_add.sv
// alarm_time_add: combinational hh:mm plus minutes with hour and midnight wrap
module alarm_time_add
    import alarm_pkg::*;
(
    input  logic [4:0] hour,
    input  logic [5:0] minute,
    input  logic [5:0] add,
    output logic [4:0] sum_hour,
    output logic [5:0] sum_minute
);
    logic [6:0] m_raw;
    logic carry;
    always_comb begin
        m_raw = {1'b0, minute} + {1'b0, add};
        carry = m_raw >= 7'(MIN_PER_HOUR);
        sum_minute = carry ? 6'(m_raw - 7'(MIN_PER_HOUR)) : m_raw[5:0];
        sum_hour = !carry ? hour : (hour == 5'(HOURS_PER_DAY - 1)) ? 5'd0 : hour + 5'd1;
    end
endmodule

// File: rtl/alarm_scheduler.sv
// alarm_scheduler: round-robin multi-slot alarm sharing one ringer, with stop/snooze sequencing
module alarm_scheduler
    import alarm_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int SNOOZE_MIN = 10,
    parameter int MAX_SNOOZE = 3,
    localparam int SW = $clog2(NUM_SLOTS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [5:0]           minute_counter,
    input  logic [4:0]           ore_counter,
    input  logic                 wr_en,
    output logic                 wr_ready,
    input  logic [SW-1:0]        wr_slot,
    input  logic                 wr_enable,
    input  logic [5:0]           wr_minute,
    input  logic [4:0]           wr_ore,
    input  logic                 stop,
    input  logic                 snooze,
    output logic                 ring,
    output logic [SW-1:0]        ring_slot,
    output logic [NUM_SLOTS-1:0] armed_mask
);
    localparam int CW = $clog2(MAX_SNOOZE + 2);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_SNOOZE);
    localparam logic [5:0] SNOOZE_ADD = 6'(SNOOZE_MIN);

    state_t state;
    logic [SW-1:0] idx;
    logic [NUM_SLOTS-1:0] armed, fired;
    logic [4:0] prog_h [NUM_SLOTS];
    logic [5:0] prog_m [NUM_SLOTS];
    logic [4:0] act_h [NUM_SLOTS];
    logic [5:0] act_m [NUM_SLOTS];
    logic [CW-1:0] cnt [NUM_SLOTS];
    logic [5:0] prev_min;
    logic wr_fire, min_chg, hit, snz_stop;
    logic [4:0] snz_h;
    logic [5:0] snz_m;

    assign wr_ready = state == SCAN;
    assign armed_mask = armed;

    // a write to the slot under the comparator suppresses that cycle's compare
    always_comb begin
        wr_fire = wr_en && wr_ready;
        min_chg = prev_min != minute_counter;
        hit = armed[idx] && !fired[idx] && act_h[idx] == ore_counter && act_m[idx] == minute_counter
              && !(wr_fire && wr_slot == idx);
        snz_stop = cnt[ring_slot] == MAX_CNT;
    end

    alarm_time_add u_add (
        .hour(act_h[ring_slot]),
        .minute(act_m[ring_slot]),
        .add(SNOOZE_ADD),
        .sum_hour(snz_h),
        .sum_minute(snz_m)
    );

    always_ff @(posedge clock) begin
        prev_min <= minute_counter;
        if (reset) begin
            state <= SCAN;
            idx <= '0;
            ring <= 1'b0;
            ring_slot <= '0;
            armed <= '0;
            fired <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                prog_h[i] <= INVALID_HOUR;
                prog_m[i] <= INVALID_MIN;
                act_h[i] <= INVALID_HOUR;
                act_m[i] <= INVALID_MIN;
                cnt[i] <= '0;
            end
        end else begin
            if (min_chg) fired <= '0;
            case (state)
                SCAN: begin
                    idx <= idx + 1'b1;
                    if (wr_fire) begin
                        armed[wr_slot] <= wr_enable;
                        prog_h[wr_slot] <= wr_ore;
                        prog_m[wr_slot] <= wr_minute;
                        act_h[wr_slot] <= wr_ore;
                        act_m[wr_slot] <= wr_minute;
                        fired[wr_slot] <= 1'b0;
                        cnt[wr_slot] <= '0;
                    end
                    if (hit) begin
                        state <= RING;
                        ring <= 1'b1;
                        ring_slot <= idx;
                        fired[idx] <= 1'b1;
                    end
                end
                RING: begin
                    if (stop) begin
                        state <= SCAN;
                        ring <= 1'b0;
                        act_h[ring_slot] <= prog_h[ring_slot];
                        act_m[ring_slot] <= prog_m[ring_slot];
                        cnt[ring_slot] <= '0;
                    end else if (snooze || min_chg) begin
                        state <= SNZ;
                        ring <= 1'b0;
                    end
                end
                SNZ: begin
                    state <= SCAN;
                    act_h[ring_slot] <= snz_stop ? prog_h[ring_slot] : snz_h;
                    act_m[ring_slot] <= snz_stop ? prog_m[ring_slot] : snz_m;
                    cnt[ring_slot] <= snz_stop ? '0 : cnt[ring_slot] + 1'b1;
                end
                default: state <= SCAN;
            endcase
        end
    end
endmodule

// File: tb/tb_alarm_scheduler.sv
// tb_alarm_scheduler: vector table, directed corner sequences and randomized snooze checks
module tb_alarm_scheduler;
    localparam int NS = 4;
    localparam int SNOOZE_MIN = 10;
    localparam int MAX_SNOOZE = 3;
    localparam int SW = $clog2(NS);
    localparam int IH = 31;
    localparam int IM = 63;
    localparam int DAY = 24 * 60;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [5:0] minute_counter = '0;
    logic [4:0] ore_counter = '0;
    logic wr_en = 1'b0, wr_enable = 1'b0, stop = 1'b0, snooze = 1'b0;
    logic [SW-1:0] wr_slot = '0;
    logic [5:0] wr_minute = '0;
    logic [4:0] wr_ore = '0;
    logic wr_ready, ring;
    logic [SW-1:0] ring_slot;
    logic [NS-1:0] armed_mask;

    int compared = 0;
    int mismatched = 0;

    alarm_scheduler #(.NUM_SLOTS(NS), .SNOOZE_MIN(SNOOZE_MIN), .MAX_SNOOZE(MAX_SNOOZE)) dut (
        .clock(clock), .reset(reset), .minute_counter(minute_counter), .ore_counter(ore_counter),
        .wr_en(wr_en), .wr_ready(wr_ready), .wr_slot(wr_slot), .wr_enable(wr_enable),
        .wr_minute(wr_minute), .wr_ore(wr_ore), .stop(stop), .snooze(snooze),
        .ring(ring), .ring_slot(ring_slot), .armed_mask(armed_mask)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int slot;
        bit en;
        int ph, pm, th, tm;
        bit exp;
    } vec_t;
    vec_t vecs[6];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int tadd(input int t, input int n);
        return (t + n * SNOOZE_MIN) % DAY;
    endfunction

    task automatic set_t(input int t);
        ore_counter = 5'(t / 60);
        minute_counter = 6'(t % 60);
    endtask

    task automatic set_idle();
        ore_counter = 5'(IH);
        minute_counter = 6'(IM);
    endtask

    task automatic write_slot(input int s, input bit en, input int h, input int m);
        wr_en = 1'b1;
        wr_slot = SW'(s);
        wr_enable = en;
        wr_ore = 5'(h);
        wr_minute = 6'(m);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_ring(input int bound, output bit got);
        got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            tick();
            got = ring;
        end
    endtask

    task automatic quiet(input int n, output bit seen);
        seen = 1'b0;
        repeat (n) begin
            tick();
            if (ring) seen = 1'b1;
        end
    endtask

    task automatic pulse(input bit s, input bit z, input string name);
        stop = s;
        snooze = z;
        tick();
        stop = 1'b0;
        snooze = 1'b0;
        check(name, ring, 0);
    endtask

    task automatic fire_at(input int t, input int slot, input string name);
        bit got;
        set_idle();
        tick();
        set_t(t);
        wait_ring(NS + 2, got);
        check({name, "_ring"}, got, 1);
        check({name, "_slot"}, ring_slot, slot);
    endtask

    initial begin
        bit got, seen;
        int t0, s, k;
        vecs[0] = '{1, 1, 7, 30, 7, 30, 1};
        vecs[1] = '{2, 1, 12, 0, 12, 1, 0};
        vecs[2] = '{3, 0, 5, 5, 5, 5, 0};
        vecs[3] = '{0, 1, 23, 59, 23, 59, 1};
        vecs[4] = '{3, 1, 0, 0, 0, 0, 1};
        vecs[5] = '{2, 1, 7, 30, 8, 30, 0};

        tick();
        tick();
        check("rst_ring", ring, 0);
        check("rst_ring_slot", ring_slot, 0);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_armed_mask", armed_mask, 0);
        reset = 1'b0;
        set_idle();
        quiet(2 * NS, seen);
        check("invalid_time_quiet", seen, 0);

        for (int v = 0; v < 6; v++) begin
            set_idle();
            tick();
            write_slot(vecs[v].slot, vecs[v].en, vecs[v].ph, vecs[v].pm);
            check($sformatf("vec%0d_armed", v), armed_mask[vecs[v].slot], vecs[v].en);
            set_t(vecs[v].th * 60 + vecs[v].tm);
            wait_ring(NS + 2, got);
            check($sformatf("vec%0d_ring", v), got, vecs[v].exp);
            if (got) begin
                if (vecs[v].exp) check($sformatf("vec%0d_slot", v), ring_slot, vecs[v].slot);
                pulse(1, 0, $sformatf("vec%0d_stop", v));
            end
            write_slot(vecs[v].slot, 0, vecs[v].ph, vecs[v].pm);
        end

        write_slot(1, 1, 7, 30);
        fire_at(7 * 60 + 30, 1, "s730");
        check("ring_wr_ready", wr_ready, 0);
        write_slot(3, 1, 7, 30);
        pulse(1, 0, "s730_stop");
        check("ring_write_ignored", armed_mask[3], 0);
        quiet(2 * NS, seen);
        check("no_rering_same_minute", seen, 0);
        fire_at(7 * 60 + 30, 1, "s730_again");
        pulse(1, 0, "s730_again_stop");

        for (int j = 0; j <= MAX_SNOOZE; j++) begin
            t0 = tadd(7 * 60 + 30, j);
            fire_at(t0, 1, $sformatf("auto%0d", j));
            set_t(t0 + 1);
            tick();
            check($sformatf("auto%0d_drop", j), ring, 0);
            tick();
        end
        set_idle();
        tick();
        set_t(tadd(7 * 60 + 30, MAX_SNOOZE + 1));
        quiet(2 * NS, seen);
        check("auto_forced_stop_quiet", seen, 0);
        fire_at(7 * 60 + 30, 1, "auto_back_to_prog");
        pulse(1, 0, "auto_stop");
        write_slot(1, 0, 7, 30);

        write_slot(0, 1, 23, 55);
        fire_at(23 * 60 + 55, 0, "wrap");
        pulse(0, 1, "wrap_snooze");
        tick();
        fire_at(5, 0, "wrap_0005");
        pulse(1, 0, "wrap_stop");
        write_slot(0, 0, 23, 55);

        write_slot(1, 1, 10, 50);
        fire_at(10 * 60 + 50, 1, "h1050");
        pulse(0, 1, "h1050_snooze");
        tick();
        fire_at(11 * 60, 1, "h1100");
        pulse(1, 0, "h1100_stop");
        fire_at(10 * 60 + 50, 1, "both");
        pulse(1, 1, "both_pulse");
        tick();
        set_idle();
        tick();
        set_t(11 * 60);
        quiet(2 * NS, seen);
        check("both_no_snooze", seen, 0);
        fire_at(10 * 60 + 50, 1, "both_prog");

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midring_rst_ring", ring, 0);
        check("midring_rst_mask", armed_mask, 0);
        check("midring_rst_ready", wr_ready, 1);
        set_t(5 * 60 + 59);
        write_slot(0, 1, 6, 0);
        write_slot(2, 1, 6, 0);
        tick();
        tick();
        set_t(6 * 60);
        wait_ring(NS + 2, got);
        check("multi_first_ring", got, 1);
        check("multi_first_slot", ring_slot, 0);
        pulse(1, 0, "multi_first_stop");
        wait_ring(NS + 1, got);
        check("multi_second_ring", got, 1);
        check("multi_second_slot", ring_slot, 2);
        pulse(1, 0, "multi_second_stop");

        for (int it = 0; it < 10; it++) begin
            t0 = int'($urandom_range(0, DAY - 1));
            s = int'($urandom_range(0, NS - 1));
            k = int'($urandom_range(0, MAX_SNOOZE));
            set_idle();
            for (int i = 0; i < NS; i++) write_slot(i, i == s, t0 / 60, t0 % 60);
            fire_at(t0, s, $sformatf("rnd%0d_fire", it));
            for (int j = 1; j <= k; j++) begin
                pulse(0, 1, $sformatf("rnd%0d_snz%0d", it, j));
                tick();
                fire_at(tadd(t0, j), s, $sformatf("rnd%0d_snz%0d", it, j));
            end
            if (k == MAX_SNOOZE) begin
                pulse(0, 1, $sformatf("rnd%0d_forced", it));
                tick();
                set_idle();
                tick();
                set_t(tadd(t0, k + 1));
                quiet(2 * NS, seen);
                check($sformatf("rnd%0d_forced_quiet", it), seen, 0);
            end else begin
                pulse(1, 0, $sformatf("rnd%0d_stop", it));
            end
            fire_at(t0, s, $sformatf("rnd%0d_prog", it));
            pulse(1, 0, $sformatf("rnd%0d_end", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/alarm_scheduler.md
# alarm_scheduler

Multi-slot alarm controller that shares a single ringer output among NUM_SLOTS programmable alarms. Slots are written over a UART-driven write port and scanned round-robin against the live hh:mm from the clock counters. The block arbitrates which slot rings and sequences stop/snooze, including +SNOOZE_MIN wrap-around. It sits between the UART command decoder and the LED/buzzer driver, next to the time counters.

## Interface
- NUM_SLOTS, 4: alarm slots; power of two, 2..8
- SNOOZE_MIN, 10: minutes added per snooze, 1..59
- MAX_SNOOZE, 3: snoozes allowed per firing before forced stop
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- minute_counter  in  6  current minute, 0..59
- ore_counter  in  5  current hour, 0..23
- wr_en  in  1  slot write request
- wr_ready  out  1  write accepted when wr_en & wr_ready
- wr_slot  in  $clog2(NUM_SLOTS)  target slot
- wr_enable  in  1  slot armed bit
- wr_minute  in  6  programmed minute
- wr_ore  in  5  programmed hour
- stop  in  1  pulse: silence ring, slot returns to programmed time
- snooze  in  1  pulse: silence ring, re-arm SNOOZE_MIN later
- ring  out  1  alarm sounding
- ring_slot  out  $clog2(NUM_SLOTS)  slot currently ringing
- armed_mask  out  NUM_SLOTS  per-slot armed bit

## Operation
- Per slot: armed, prog time (h,m), active time (h,m), fired flag, snooze count.
- Reset: armed=0, prog/active = 31:63 (invalid, never matches), fired=0, counts=0; ring=0, ring_slot=0, wr_ready=1, armed_mask=0, state=SCAN, scan index=0.
- Write (SCAN only): sets armed, prog and active to wr time, fired=0, count=0. Write to slot equal to scan index in same cycle: write wins, no compare that cycle.
- States: SCAN, RING, SNZ.
- SCAN: each cycle compare slot[idx]; hit = armed & !fired & active == current time. Hit -> RING, ring_slot=idx, fired[idx]=1. idx increments mod NUM_SLOTS every cycle.
- RING: ring=1, wr_ready=0. stop -> active=prog, count=0, SCAN. snooze, or minute_counter change (auto-snooze) -> SNZ. stop and snooze same cycle: stop wins.
- SNZ (1 cycle): if count==MAX_SNOOZE treat as stop; else active += SNOOZE_MIN, count++, -> SCAN.
- Time add: m' = m+S; if m' >= 60 then m' -= 60, h+1; h 23 -> 0. 23:55 + 10 = 00:05; 10:50 + 10 = 11:00.
- Minute change (registered prev minute != minute_counter): clear all fired flags that cycle.
- Multiple slots matching same minute: scan order; others ring sequentially after resolution if minute unchanged.
- Disarmed slot keeps times; never matches.

## Timing
- Hit registered: ring rises 1 cycle after compare of matching slot; worst-case detection NUM_SLOTS cycles after time change.
- stop/snooze sampled in RING; ring falls next cycle.
- wr_ready low in RING and SNZ; combinational from state. Write latency 1 cycle; armed_mask updates next cycle.
- Reset mid-RING: ring=0 next cycle, all slots cleared.

## Structure
- Package alarm_pkg: MIN_PER_HOUR=60, HOURS_PER_DAY=24, INVALID_MIN=6'h3F, INVALID_HOUR=5'h1F, state encoding SCAN/RING/SNZ.
- Sub-module alarm_time_add: combinational (h,m)+minutes with wrap, used by SNZ.
- Slot storage as arrays indexed by slot; single shared comparator driven by scan index.

## Test plan
- Write slot1 07:30 armed, drive time 07:30 -> ring=1, ring_slot=1 within 5 cycles; stop -> ring=0, slot1 active stays 07:30, no re-ring same minute.
- Slot0 23:55, fire, snooze -> active 00:05; drive 00:05 -> rings again.
- Fire, hold no input, minute 30->31 -> auto-snooze, active 07:40, count=1; after 3 snoozes 4th resolution acts as stop.
- Slots 0 and 2 both 06:00 -> slot0 rings first; stop -> slot2 rings within NUM_SLOTS+1 cycles.
- wr_en during RING -> wr_ready=0, slot unchanged; stop+snooze same cycle -> stop behaviour.
- Reset asserted while ringing -> ring=0, armed_mask=0 next cycle; time 31:63 never matches.
